// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Number of 32-bit words addressable with an addr_w-bit byte address.
  function automatic int unsigned cap_words(input int unsigned addr_w);
    return (32'd1 << addr_w) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts incoming bytes into a 32-bit word; word_c is the value the register takes next.
module byte_packer #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_c
);

  logic [31:0] word_q;

  // Little-endian shifts right so the first byte ends in [7:0]; big-endian shifts left.
  always_comb begin
    word_c = word_q;
    if (clear) begin
      word_c = '0;
    end else if (shift_en) begin
      if (BIG_ENDIAN) word_c = {word_q[23:0], byte_in};
      else            word_c = {byte_in, word_q[31:8]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) word_q <= '0;
    else      word_q <= word_c;
  end

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into 32-bit words, writes them to instruction memory, then releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W-2:0] num_words,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              start,
  output logic              err
);

  localparam int unsigned NW_W = ADDR_W - 1;
  localparam int unsigned WA_W = ADDR_W - 2;
  localparam int unsigned CAP  = cap_words(ADDR_W);

  state_e            state_q, state_d;
  logic [NW_W-1:0]   word_cnt_q, word_cnt_d, word_cnt_inc;
  logic [NW_W-1:0]   num_words_q, num_words_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              idle_like_c, len_ok_c;
  logic              pack_shift_c, pack_clear_c;
  logic [31:0]       pack_word_c;

  // Packer controls depend only on registered state and inputs, keeping the comb path acyclic.
  assign idle_like_c  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
  assign len_ok_c     = (num_words != '0) && (32'(num_words) <= CAP);
  assign pack_shift_c = (state_q == COLLECT) && byte_valid;
  assign pack_clear_c = idle_like_c && load_req && len_ok_c;
  assign word_cnt_inc = word_cnt_q + NW_W'(1);

  byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (pack_shift_c),
    .clear    (pack_clear_c),
    .byte_in  (byte_data),
    .word_c   (pack_word_c)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    num_words_d = num_words_q;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_req) begin
          num_words_d = num_words;
          if (num_words == '0) begin
            state_d = DONE;
          end else if (!len_ok_c) begin
            state_d = ERROR;
          end else begin
            state_d    = COLLECT;
            word_cnt_d = '0;
            byte_cnt_d = '0;
          end
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = {word_cnt_q[WA_W-1:0], 2'b00};
            wdata_d = pack_word_c;
          end
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt_inc;
        state_d    = (word_cnt_inc == num_words_q) ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      num_words_q <= '0;
      byte_ready  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      start       <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      num_words_q <= num_words_d;
      byte_ready  <= (state_d == COLLECT);
      mem_we      <= (state_d == WRITE);
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      busy        <= (state_d == COLLECT) || (state_d == WRITE);
      start       <= (state_d == DONE);
      err         <= (state_d == ERROR);
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the core's instruction fetch path.
- Receives a byte stream over a valid/ready handshake and packs every four bytes into a 32-bit instruction word.
- Writes each word into instruction memory at consecutive word addresses.
- After the last word is written, raises `start` to release the PC. While loading, the core is held idle because `start` is low.

Parameters:
- ADDR_W, 8: instruction memory byte-address width; must match the PC address width.
- BIG_ENDIAN, 0: 0 = first received byte goes to wdata[7:0]; 1 = first received byte goes to wdata[31:24].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load_req  in  1  single-cycle pulse; latches num_words and begins a load.
- num_words  in  ADDR_W-1  number of 32-bit words to load.
- byte_data  in  8  incoming program byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  byte address of the write; always a multiple of 4.
- mem_wdata  out  32  packed instruction word.
- busy  out  1  load in progress.
- start  out  1  program loaded; core may run.
- err  out  1  requested length exceeded memory capacity.

Behaviour:
- Reset: clk and rst are the single clock and reset; reset is asynchronous, active-low, on port rst.
  - While rst=0, all outputs are 0, the FSM is in IDLE, and the counters and packer are cleared.
  - Reset asserted mid-load aborts immediately; no further mem_we is issued.
- Capacity: CAP = 2^ADDR_W / 4 words (64 for the default ADDR_W).
- States:
  - IDLE: byte_ready=0, busy=0. On load_req:
    - num_words=0 → DONE.
    - num_words>CAP → ERROR.
    - otherwise → COLLECT, with word_cnt=0, byte_cnt=0, addr=0.
  - COLLECT: byte_ready=1, busy=1.
    - A byte is transferred only in a cycle where byte_valid and byte_ready are both 1.
    - Each transfer shifts byte_data into the packer and increments byte_cnt (2-bit, wraps at 4).
    - On the 4th transfer → WRITE.
  - WRITE: lasts exactly one cycle. byte_ready=0, mem_we=1, mem_addr=word_cnt*4, mem_wdata=packed word.
    - Afterwards word_cnt increments.
    - If word_cnt+1 == latched num_words → DONE, else → COLLECT.
  - DONE: start=1 (level), busy=0, byte_ready=0. Stays here until load_req, which re-evaluates num_words exactly as in IDLE.
  - ERROR: err=1, start=0, busy=0, byte_ready=0. Nothing is written. load_req re-evaluates as in IDLE, and err clears in the same cycle the new load begins.
- Latency:
  - The 4th byte accepted in cycle N gives mem_we=1 in cycle N+1.
  - The next byte may be accepted at the earliest in cycle N+2.
  - The last write in cycle M gives start=1 in cycle M+1.
- Handshake rules:
  - byte_data is ignored whenever byte_ready=0.
  - byte_valid gaps of any length are legal; packer contents are retained across them.
  - byte_valid asserted in IDLE, DONE or ERROR is dropped; the loader never stalls on it.
- load_req during COLLECT or WRITE is ignored; the load in progress completes.
- mem_addr wrap: unreachable, because num_words≤CAP is checked up front.
- mem_we is asserted only in WRITE. mem_addr and mem_wdata are held stable outside WRITE.

Decomposition:
- Package imem_loader_pkg:
  - state enum {IDLE, COLLECT, WRITE, DONE, ERROR};
  - localparam BYTES_PER_WORD=4;
  - capacity function cap_words(ADDR_W).
- Sub-module byte_packer:
  - 32-bit shift register with shift_en, clear and BIG_ENDIAN parameter;
  - outputs the packed word;
  - clk/rst as above.
- The FSM, counters and output registers stay in imem_loader.

Test Plan:
- Basic load: load_req with num_words=2, then bytes 0x01,0x02,0x03,0x04,0x05,0x06,0x07,0x08 with valid held high → mem_we pulses at addr 0x00 wdata 0x04030201 and at addr 0x04 wdata 0x08070605; start=1 one cycle after the second write; busy=0.
- Big-endian: BIG_ENDIAN=1, same stimulus → words 0x01020304 and 0x05060708.
- Gaps and out-of-state bytes: random byte_valid gaps within a word, and byte_valid=1 while in WRITE → identical words written; byte_ready=0 in the WRITE cycle; no byte lost or duplicated.
- Length boundaries:
  - num_words=0 → start=1 the next cycle, no mem_we.
  - num_words=65 (ADDR_W=8) → err=1, start=0, no mem_we.
  - num_words=64 → last write at addr 0xFC.
- Reset and restart:
  - rst=0 after 2 bytes of word 1 → all outputs 0 asynchronously.
  - Release, then load_req with num_words=1 and bytes 0xAA..0xDD → single write at addr 0x00 wdata 0xDDCCBBAA.
- Reload from DONE: load_req with num_words=1 → start drops the next cycle; the new word is written at addr 0x00; start rises again.
